processing_pipeline: RTL

PROCESSING_PIPELINE -- requirements
Module: processing_pipeline

---
 rtl/pb_pkg.sv | 33 +++
 rtl/alu_bf16.sv | 58 +++++
 rtl/pb_ctrl_fsm.sv | 149 ++++++++++++++
 rtl/reg_file.sv | 32 +++
 rtl/processing_pipeline.sv | 90 +++++++++
 5 files changed

// File: rtl/pb_pkg.sv
// Shared definitions for the vector processing pipeline: opcodes, control
// states and instruction field positions.
package pb_pkg;

    typedef enum logic [3:0] {
        OP_ALU   = 4'd0,
        OP_STORE = 4'd1,
        OP_LOAD  = 4'd2,
        OP_HALT  = 4'd3,
        OP_JUMP  = 4'd4
    } opcode_e;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_FETCH    = 3'd1,
        ST_EXEC     = 3'd2,
        ST_ALU_WAIT = 3'd3,
        ST_MEM_WAIT = 3'd4,
        ST_HALTED   = 3'd5
    } state_e;

    localparam int OPC_LSB  = 28;
    localparam int ALUC_LSB = 24;
    localparam int DST_LSB  = 16;
    localparam int SRC1_LSB = 8;
    localparam int SRC2_LSB = 0;
    localparam int ADDR_LSB = 0;

    function automatic logic [3:0] instr_opcode(input logic [31:0] instr);
        return instr[OPC_LSB +: 4];
    endfunction

endpackage

// File: rtl/alu_bf16.sv
// Single-lane bfloat16 ALU: add, subtract, pass-through. Truncating rounding,
// subnormals flushed to zero, overflow saturates to infinity.
module alu_bf16 (
    input  logic [3:0]  i_ctrl,
    input  logic [15:0] i_a,
    input  logic [15:0] i_b,
    output logic [15:0] o_y
);

    function automatic logic [15:0] bf16_add(input logic [15:0] a, input logic [15:0] b);
        logic [15:0] x, y;
        logic [7:0]  ex, dexp, mx, my, m;
        logic [8:0]  sum;
        logic [3:0]  lz;
        // x holds the larger magnitude so the difference path never goes negative
        if (a[14:0] >= b[14:0]) begin
            x = a; y = b;
        end else begin
            x = b; y = a;
        end
        ex   = x[14:7];
        dexp = x[14:7] - y[14:7];
        mx   = (x[14:7] != 8'd0) ? {1'b1, x[6:0]} : 8'd0;
        my   = (y[14:7] != 8'd0) ? {1'b1, y[6:0]} : 8'd0;
        my   = (dexp > 8'd7) ? 8'd0 : (my >> dexp);
        if (x[15] == y[15]) begin
            sum = {1'b0, mx} + {1'b0, my};
            if (sum[8]) begin
                if (ex >= 8'd254) return {x[15], 8'hFF, 7'h00};
                else return {x[15], ex + 8'd1, sum[7:1]};
            end else begin
                return {x[15], ex, sum[6:0]};
            end
        end else begin
            m  = mx - my;
            lz = 4'd8;
            for (int k = 0; k < 8; k++) begin
                lz = m[k] ? 4'(7 - k) : lz;
            end
            if ((m == 8'd0) || ({4'd0, lz} >= ex)) begin
                return 16'h0000;
            end else begin
                m = m << lz;
                return {x[15], ex - {4'd0, lz}, m[6:0]};
            end
        end
    endfunction

    // operation select
    always_comb begin
        case (i_ctrl)
            4'h0:    o_y = bf16_add(i_a, i_b);
            4'h1:    o_y = bf16_add(i_a, {~i_b[15], i_b[14:0]});
            default: o_y = i_a;
        endcase
    end

endmodule

// File: rtl/pb_ctrl_fsm.sv
// Pipeline controller: sequencing FSM, program counter, instruction register
// and retired-instruction counter.
module pb_ctrl_fsm
    import pb_pkg::*;
#(
    parameter int PC_W    = 16,
    parameter int REG_AW  = 8,
    parameter int ALU_LAT = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              i_start,
    input  logic              i_imem_valid,
    input  logic [31:0]       i_imem_data,
    input  logic              i_mem_ack,
    output logic              o_imem_req,
    output logic [PC_W-1:0]   o_imem_addr,
    output logic              o_mem_rd_req,
    output logic              o_mem_wr_req,
    output logic [15:0]       o_mem_addr,
    output logic [3:0]        o_alu_ctrl,
    output logic [REG_AW-1:0] o_dst,
    output logic [REG_AW-1:0] o_src1,
    output logic [REG_AW-1:0] o_src2,
    output logic              o_rf_we,
    output logic              o_rf_wsel_mem,
    output logic              o_busy,
    output logic              o_halted,
    output logic [31:0]       o_retired
);

    localparam int CNT_W = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ALU_LAT - 1);

    state_e           r_state, w_state_nxt;
    logic [PC_W-1:0]  r_pc, w_pc_nxt;
    logic [31:0]      r_instr, w_instr_nxt;
    logic [31:0]      r_retired, w_retired_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [3:0]       w_opc;

    assign w_opc = instr_opcode(r_instr);

    // state registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_pc      <= '0;
            r_instr   <= 32'd0;
            r_retired <= 32'd0;
            r_cnt     <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_pc      <= w_pc_nxt;
            r_instr   <= w_instr_nxt;
            r_retired <= w_retired_nxt;
            r_cnt     <= w_cnt_nxt;
        end
    end

    // next-state and register-write decode
    always_comb begin
        w_state_nxt   = r_state;
        w_pc_nxt      = r_pc;
        w_instr_nxt   = r_instr;
        w_retired_nxt = r_retired;
        w_cnt_nxt     = r_cnt;
        o_rf_we       = 1'b0;
        o_rf_wsel_mem = 1'b0;
        case (r_state)
            ST_IDLE, ST_HALTED: begin
                if (i_start) begin
                    w_pc_nxt      = '0;
                    w_retired_nxt = 32'd0;
                    w_state_nxt   = ST_FETCH;
                end else begin
                    w_state_nxt   = r_state;
                end
            end
            ST_FETCH: begin
                if (i_imem_valid) begin
                    w_instr_nxt = i_imem_data;
                    w_state_nxt = ST_EXEC;
                end else begin
                    w_state_nxt = ST_FETCH;
                end
            end
            ST_EXEC: begin
                case (w_opc)
                    OP_ALU: begin
                        w_cnt_nxt   = '0;
                        w_state_nxt = ST_ALU_WAIT;
                    end
                    OP_LOAD, OP_STORE: w_state_nxt = ST_MEM_WAIT;
                    OP_HALT: begin
                        w_retired_nxt = r_retired + 32'd1;
                        w_state_nxt   = ST_HALTED;
                    end
                    OP_JUMP: begin
                        w_pc_nxt      = r_instr[PC_W-1:0];
                        w_retired_nxt = r_retired + 32'd1;
                        w_state_nxt   = ST_FETCH;
                    end
                    default: begin
                        w_pc_nxt      = r_pc + PC_W'(1);
                        w_retired_nxt = r_retired + 32'd1;
                        w_state_nxt   = ST_FETCH;
                    end
                endcase
            end
            ST_ALU_WAIT: begin
                if (r_cnt == CNT_LAST) begin
                    o_rf_we       = 1'b1;
                    w_pc_nxt      = r_pc + PC_W'(1);
                    w_retired_nxt = r_retired + 32'd1;
                    w_state_nxt   = ST_FETCH;
                end else begin
                    w_cnt_nxt     = r_cnt + CNT_W'(1);
                end
            end
            ST_MEM_WAIT: begin
                if (i_mem_ack) begin
                    o_rf_we       = (w_opc == OP_LOAD);
                    o_rf_wsel_mem = 1'b1;
                    w_pc_nxt      = r_pc + PC_W'(1);
                    w_retired_nxt = r_retired + 32'd1;
                    w_state_nxt   = ST_FETCH;
                end else begin
                    w_state_nxt   = ST_MEM_WAIT;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign o_imem_req   = (r_state == ST_FETCH);
    assign o_imem_addr  = r_pc;
    assign o_mem_rd_req = (r_state == ST_MEM_WAIT) && (w_opc == OP_LOAD);
    assign o_mem_wr_req = (r_state == ST_MEM_WAIT) && (w_opc == OP_STORE);
    assign o_mem_addr   = r_instr[ADDR_LSB +: 16];
    assign o_alu_ctrl   = r_instr[ALUC_LSB +: 4];
    assign o_dst        = r_instr[DST_LSB +: REG_AW];
    assign o_src1       = r_instr[SRC1_LSB +: REG_AW];
    assign o_src2       = r_instr[SRC2_LSB +: REG_AW];
    assign o_busy       = (r_state != ST_IDLE) && (r_state != ST_HALTED);
    assign o_halted     = (r_state == ST_HALTED);
    assign o_retired    = r_retired;

endmodule

// File: rtl/reg_file.sv
// Vector register file: three combinational read ports, one write port.
// Contents are deliberately not reset.
module reg_file #(
    parameter int AW = 8,
    parameter int DW = 512
) (
    input  logic          clock,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic [AW-1:0] i_raddr_a,
    input  logic [AW-1:0] i_raddr_b,
    input  logic [AW-1:0] i_raddr_c,
    output logic [DW-1:0] o_rdata_a,
    output logic [DW-1:0] o_rdata_b,
    output logic [DW-1:0] o_rdata_c
);

    logic [DW-1:0] r_mem [2**AW];

    // write port
    always_ff @(posedge clock) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata_a = r_mem[i_raddr_a];
    assign o_rdata_b = r_mem[i_raddr_b];
    assign o_rdata_c = r_mem[i_raddr_c];

endmodule

// File: rtl/processing_pipeline.sv
// Vector processing pipeline top: controller, vector register file and one
// bfloat16 ALU per lane.
module processing_pipeline
    import pb_pkg::*;
#(
    parameter int CORES   = 32,
    parameter int BITS    = 16,
    parameter int PC_W    = 16,
    parameter int REG_AW  = 8,
    parameter int ALU_LAT = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    output logic                  imem_req,
    output logic [PC_W-1:0]       imem_addr,
    input  logic                  imem_valid,
    input  logic [31:0]           imem_data,
    output logic                  mem_rd_req,
    output logic                  mem_wr_req,
    output logic [15:0]           mem_addr,
    output logic [CORES*BITS-1:0] mem_wr_data,
    input  logic [CORES*BITS-1:0] mem_rd_data,
    input  logic                  mem_ack,
    output logic                  busy,
    output logic                  halted,
    output logic [31:0]           retired
);

    logic [3:0]            w_alu_ctrl;
    logic [REG_AW-1:0]     w_dst, w_src1, w_src2;
    logic                  w_rf_we, w_rf_wsel_mem;
    logic [CORES*BITS-1:0] w_rd_a, w_rd_b, w_alu_y, w_wdata;

    pb_ctrl_fsm #(
        .PC_W    (PC_W),
        .REG_AW  (REG_AW),
        .ALU_LAT (ALU_LAT)
    ) u_ctrl (
        .clock         (clock),
        .reset         (reset),
        .i_start       (start),
        .i_imem_valid  (imem_valid),
        .i_imem_data   (imem_data),
        .i_mem_ack     (mem_ack),
        .o_imem_req    (imem_req),
        .o_imem_addr   (imem_addr),
        .o_mem_rd_req  (mem_rd_req),
        .o_mem_wr_req  (mem_wr_req),
        .o_mem_addr    (mem_addr),
        .o_alu_ctrl    (w_alu_ctrl),
        .o_dst         (w_dst),
        .o_src1        (w_src1),
        .o_src2        (w_src2),
        .o_rf_we       (w_rf_we),
        .o_rf_wsel_mem (w_rf_wsel_mem),
        .o_busy        (busy),
        .o_halted      (halted),
        .o_retired     (retired)
    );

    // the store source shares the dst field, hence read port c on w_dst
    reg_file #(
        .AW (REG_AW),
        .DW (CORES*BITS)
    ) u_rf (
        .clock     (clock),
        .i_we      (w_rf_we),
        .i_waddr   (w_dst),
        .i_wdata   (w_wdata),
        .i_raddr_a (w_src1),
        .i_raddr_b (w_src2),
        .i_raddr_c (w_dst),
        .o_rdata_a (w_rd_a),
        .o_rdata_b (w_rd_b),
        .o_rdata_c (mem_wr_data)
    );

    assign w_wdata = w_rf_wsel_mem ? mem_rd_data : w_alu_y;

    for (genvar g = 0; g < CORES; g++) begin : g_lane
        alu_bf16 u_alu (
            .i_ctrl (w_alu_ctrl),
            .i_a    (w_rd_a[g*BITS +: BITS]),
            .i_b    (w_rd_b[g*BITS +: BITS]),
            .o_y    (w_alu_y[g*BITS +: BITS])
        );
    end

endmodule
